// File: rtl/bit_serial_mac_ctrl_pkg.sv
// rtl/bit_serial_mac_ctrl_pkg.sv - lif_pkg: shared constants, state encoding and counter-width helper
package lif_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_WWIDTH = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_t;

    // Width of a counter that must reach n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bit_serial_mac_ctrl_if.sv
// rtl/bit_serial_mac_ctrl_if.sv - request, upstream strobe and result signals of the bit-serial MAC
interface bit_serial_mac_ctrl_if #(
    parameter int WIDTH  = lif_pkg::DEF_WIDTH,
    parameter int WWIDTH = lif_pkg::DEF_WWIDTH
);
    localparam int PWIDTH = WIDTH + WWIDTH;

    logic                     start;
    logic                     clear;
    logic        [WWIDTH-1:0] weight;
    logic                     serial_bit;
    logic                     ready;
    logic                     sr_init;
    logic                     sr_load;
    logic                     sr_shift;
    logic                     done;
    logic signed [PWIDTH-1:0] product;

    modport master (
        output start, clear, weight, serial_bit,
        input  ready, sr_init, sr_load, sr_shift, done, product
    );

    modport slave (
        input  start, clear, weight, serial_bit,
        output ready, sr_init, sr_load, sr_shift, done, product
    );

endinterface

// File: rtl/bit_serial_mac_ctrl_serial_shift_add.sv
// rtl/bit_serial_mac_ctrl_serial_shift_add.sv - weight register, accumulator and bit counter (SERIAL_SIGNED_EN selects signed operand)
module serial_shift_add
    import lif_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int WWIDTH = DEF_WWIDTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clear,
    input  logic                            init,
    input  logic                            step,
    input  logic        [WWIDTH-1:0]        weight,
    input  logic                            serial_bit,
    output logic signed [WIDTH+WWIDTH-1:0]  acc_next,
    output logic                            last
);
    localparam int PWIDTH = WIDTH + WWIDTH;
    localparam int CW     = cnt_width(WIDTH);

    logic        [WWIDTH-1:0] wreg;
    logic signed [PWIDTH-1:0] acc;
    logic        [CW-1:0]     cnt;
    logic signed [PWIDTH-1:0] wext;
    logic signed [PWIDTH-1:0] term;

    // Sign-extend the weight to full product width before shifting so no bits are lost.
    assign wext = {{WIDTH{wreg[WWIDTH-1]}}, wreg};
    assign term = serial_bit ? (wext << cnt) : '0;
    assign last = (cnt == CW'(WIDTH - 1));

    // Next accumulator value; the MSB step of a two's-complement operand carries negative weight.
    always_comb begin
        acc_next = acc;
`ifdef SERIAL_SIGNED_EN
        if (last)
            acc_next = acc - term;
        else
            acc_next = acc + term;
`else
        acc_next = acc + term;
`endif
    end

    // Operand capture, accumulation and step counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wreg <= '0;
            acc  <= '0;
            cnt  <= '0;
        end else if (clear) begin
            acc  <= '0;
            cnt  <= '0;
        end else if (init) begin
            wreg <= weight;
            acc  <= '0;
            cnt  <= '0;
        end else if (step) begin
            acc  <= acc_next;
            cnt  <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/bit_serial_mac_ctrl.sv
// rtl/bit_serial_mac_ctrl.sv - bit-serial multiply controller driving the upstream shift register (SERIAL_SIGNED_EN: signed operand)
module bit_serial_mac_ctrl
    import lif_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int WWIDTH = DEF_WWIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    bit_serial_mac_ctrl_if.slave bus
);
    localparam int PWIDTH = WIDTH + WWIDTH;

    state_t                   state;
    logic                     ready_q;
    logic                     done_q;
    logic signed [PWIDTH-1:0] product_q;
    logic signed [PWIDTH-1:0] acc_next;
    logic                     last;
    logic                     accept;
    logic                     step;

    // Upstream strobes: clear wins over everything, load only on an accepted start.
    assign accept       = bus.start & ready_q & ~bus.clear;
    assign step         = (state == S_RUN) & ~bus.clear;
    assign bus.sr_init  = bus.clear;
    assign bus.sr_load  = accept;
    assign bus.sr_shift = step;
    assign bus.ready    = ready_q;
    assign bus.done     = done_q;
    assign bus.product  = product_q;

    serial_shift_add #(
        .WIDTH  (WIDTH),
        .WWIDTH (WWIDTH)
    ) u_shift_add (
        .clk        (clk),
        .rst        (rst),
        .clear      (bus.clear),
        .init       (accept),
        .step       (step),
        .weight     (bus.weight),
        .serial_bit (bus.serial_bit),
        .acc_next   (acc_next),
        .last       (last)
    );

    // Control FSM with registered ready/done/product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            product_q <= '0;
        end else if (bus.clear) begin
            state     <= S_IDLE;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        state   <= S_RUN;
                        ready_q <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (last) begin
                        state     <= S_DONE;
                        product_q <= acc_next;
                        done_q    <= 1'b1;
                    end
                end
                S_DONE: begin
                    state   <= S_IDLE;
                    ready_q <= 1'b1;
                    done_q  <= 1'b0;
                end
                default: begin
                    state   <= S_IDLE;
                    ready_q <= 1'b1;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serial_mac_ctrl.sv
// tb/tb_bit_serial_mac_ctrl.sv - scoreboard bench for bit_serial_mac_ctrl (honours SERIAL_SIGNED_EN)
module tb_bit_serial_mac_ctrl;

    localparam int WIDTH  = 8;
    localparam int WWIDTH = 8;

    typedef struct {
        logic signed [15:0] p;
        int                 c;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sbq[$];
    exp_t e;

    logic [7:0] sr_q;
    logic [7:0] operand;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    bit_serial_mac_ctrl_if #(.WIDTH(WIDTH), .WWIDTH(WWIDTH)) bus ();

    bit_serial_mac_ctrl #(.WIDTH(WIDTH), .WWIDTH(WWIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Upstream serial shift register: LSB presented on one_bit_out.
    always @(posedge clk or posedge rst) begin
        if (rst)               sr_q <= 8'd0;
        else if (bus.sr_init)  sr_q <= 8'd0;
        else if (bus.sr_load)  sr_q <= operand;
        else if (bus.sr_shift) sr_q <= {1'b0, sr_q[7:1]};
    end
    assign bus.serial_bit = sr_q[0];

    // Reference product: plain integer multiply of operand and weight.
    function automatic logic signed [15:0] model(input logic [7:0] op, input logic [7:0] w);
        int a;
        int b;
        b = int'($signed(w));
`ifdef SERIAL_SIGNED_EN
        a = int'($signed(op));
`else
        a = int'(op);
`endif
        return 16'(a * b);
    endfunction

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.done === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("done_without_request", 32'(bus.done), 0);
            end else begin
                e = sbq.pop_front();
                chk("product", bus.product, e.p);
                chk("done_cycle", cyc, e.c);
                chk("ready_in_done", 32'(bus.ready), 0);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (bus.ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("ready_timeout", 32'(bus.ready), 1);
    endtask

    // Issue one multiply; returns at the sample point just after the accepting edge.
    task automatic issue(input logic [7:0] op, input logic [7:0] w, input bit push);
        exp_t x;
        wait_ready();
        operand    = op;
        bus.weight = w;
        bus.start  = 1'b1;
        if (push) begin
            x.p = model(op, w);
            x.c = cyc + WIDTH + 1;
            sbq.push_back(x);
        end
        @(negedge clk);
        bus.start  = 1'b0;
        bus.weight = 8'($urandom);
        operand    = 8'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while ((sbq.size() != 0 || bus.ready !== 1'b1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_outstanding", sbq.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"},    32'(bus.ready),    1);
        chk({tag, "_done"},     32'(bus.done),     0);
        chk({tag, "_product"},  bus.product,       0);
        chk({tag, "_sr_load"},  32'(bus.sr_load),  0);
        chk({tag, "_sr_shift"}, 32'(bus.sr_shift), 0);
        chk({tag, "_sr_init"},  32'(bus.sr_init),  0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.start  = 1'b0;
        bus.clear  = 1'b0;
        bus.weight = 8'd0;
        operand    = 8'd0;
        rst        = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Basic multiply with latency and hold checks.
        issue(8'd5, 8'd3, 1'b1);
        chk("t1_ready_low", 32'(bus.ready), 0);
        repeat (3) @(negedge clk);
        chk("t1_shift_in_run", 32'(bus.sr_shift), 1);
        repeat (4) @(negedge clk);
        chk("t1_no_early_done", 32'(bus.done), 0);
        @(negedge clk);
        chk("t1_done", 32'(bus.done), 1);
        chk("t1_product_15", bus.product, 15);
        @(negedge clk);
        chk("t1_ready_back", 32'(bus.ready), 1);
        chk("t1_done_single", 32'(bus.done), 0);
        chk("t1_product_held", bus.product, 15);

        // Directed operand/weight corners.
        issue(8'd200, 8'hFC, 1'b1); drain();
        issue(8'hF6,  8'd7,  1'b1); drain();
        issue(8'hFF,  8'h80, 1'b1); drain();
        issue(8'd0,   8'h5A, 1'b1); drain();
        issue(8'hFF,  8'h7F, 1'b1); drain();
        issue(8'h80,  8'h80, 1'b1); drain();

        // Start pulses during RUN and in the DONE cycle are ignored.
        issue(8'h9C, 8'h33, 1'b1);
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        chk("t5_no_load_in_run", 32'(bus.sr_load), 0);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        chk("t5_in_done", 32'(bus.done), 1);
        bus.start = 1'b1;
        chk("t5_no_load_in_done", 32'(bus.sr_load), 0);
        @(negedge clk);
        bus.start = 1'b0;
        chk("t5_ready_after_done", 32'(bus.ready), 1);
        repeat (14) @(negedge clk);
        chk("t5_stays_idle", 32'(bus.ready), 1);

        // Clear in the middle of RUN.
        issue(8'h77, 8'h11, 1'b0);
        repeat (3) @(negedge clk);
        bus.clear = 1'b1;
        #1;
        chk("t6_sr_init", 32'(bus.sr_init), 1);
        chk("t6_sr_shift_off", 32'(bus.sr_shift), 0);
        @(negedge clk);
        bus.clear = 1'b0;
        chk("t6_ready", 32'(bus.ready), 1);
        chk("t6_product_zero", bus.product, 0);
        chk("t6_done", 32'(bus.done), 0);
        repeat (12) @(negedge clk);

        // Asynchronous reset in the middle of RUN, then a fresh multiply.
        issue(8'h21, 8'h06, 1'b1); drain();
        issue(8'h3C, 8'h85, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid_run");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(8'hB7, 8'hE9, 1'b1); drain();

        // Randomized back-to-back and gapped traffic.
        for (int i = 0; i < 40; i++) begin
            issue(8'($urandom), 8'($urandom), 1'b1);
            repeat ($urandom_range(0, 12)) @(negedge clk);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
